multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle processor control unit: IF/ID/EX/MEM/WB/HLT state machine with
// combinationally decoded datapath strobes and a fetched-instruction counter.
module multi_cycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    input  logic             bcond,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             wwd,
    output logic             halt,
    output logic [CNT_W-1:0] num_inst
);

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HLT
    } state_t;

    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_RT  = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    state_t state;
    state_t next;
    logic   cnt_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IF;
            num_inst <= '0;
        end else begin
            state <= next;
            if (cnt_en)
                num_inst <= num_inst + CNT_W'(1);
        end
    end

    always_comb begin
        next       = state;
        cnt_en     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        wwd        = 1'b0;
        halt       = 1'b0;

        case (state)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    cnt_en   = 1'b1;
                    next     = S_ID;
                end
            end
            S_ID: begin
                next = S_IF;
                case (opcode)
                    OP_JMP: begin
                        pc_write  = 1'b1;
                        pc_source = 2'd2;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_source  = 2'd2;
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                    OP_RT: begin
                        case (funct)
                            FN_JPR: begin
                                pc_write  = 1'b1;
                                pc_source = 2'd3;
                            end
                            FN_JRL: begin
                                pc_write   = 1'b1;
                                pc_source  = 2'd3;
                                reg_write  = 1'b1;
                                reg_dst    = 2'd2;
                                mem_to_reg = 2'd2;
                            end
                            FN_WWD:  wwd  = 1'b1;
                            FN_HLT:  next = S_HLT;
                            default: if (funct < 6'd8) next = S_EX;
                        endcase
                    end
                    default: if (opcode <= OP_SWD) next = S_EX;
                endcase
            end
            S_EX: begin
                next      = S_IF;
                alu_src_a = 1'b1;
                if (opcode == OP_RT) begin
                    alu_src_b = 2'd1;
                    next      = S_WB;
                end else if (opcode >= 4'd4 && opcode <= 4'd6) begin
                    alu_src_b = 2'd2;
                    next      = S_WB;
                end else if (opcode == OP_LWD || opcode == OP_SWD) begin
                    alu_src_b = 2'd2;
                    next      = S_MEM;
                end else if (opcode <= 4'd3) begin
                    alu_src_b = 2'd1;
                    pc_source = 2'd1;
                    pc_write  = bcond;
                end else begin
                    alu_src_a = 1'b0;
                end
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_LWD) begin
                    mem_read = 1'b1;
                    if (mem_ready) next = S_WB;
                end else if (opcode == OP_SWD) begin
                    mem_write = 1'b1;
                    if (mem_ready) next = S_IF;
                end else begin
                    i_or_d = 1'b0;
                    next   = S_IF;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                next      = S_IF;
                if (opcode == OP_RT)
                    reg_dst = 2'd1;
                else if (opcode == OP_LWD)
                    mem_to_reg = 2'd1;
            end
            S_HLT: begin
                halt = 1'b1;
            end
            default: next = S_IF;
        endcase

        // State is already IF during reset; mask its fetch request so nothing leaks out.
        if (reset) begin
            cnt_en     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_source  = 2'd0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            reg_write  = 1'b0;
            reg_dst    = 2'd0;
            mem_to_reg = 2'd0;
            wwd        = 1'b0;
            halt       = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed self-checking bench for multi_cycle_control: per-instruction output
// sequences, memory wait states, halt, async reset, and 4-bit counter wrap.
module tb_multi_cycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [5:0]  funct = 6'd0;
    logic        mem_ready = 1'b0;
    logic        bcond = 1'b0;

    logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_source, alu_src_b, reg_dst, mem_to_reg;
    logic        alu_src_a, reg_write, wwd, halt;
    logic [15:0] num_inst;

    logic        mem_read4, mem_write4, i_or_d4, ir_write4, pc_write4;
    logic [1:0]  pc_source4, alu_src_b4, reg_dst4, mem_to_reg4;
    logic        alu_src_a4, reg_write4, wwd4, halt4;
    logic [3:0]  num_inst4;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    multi_cycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .bcond(bcond),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .wwd(wwd), .halt(halt),
        .num_inst(num_inst)
    );

    multi_cycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .bcond(bcond),
        .mem_read(mem_read4), .mem_write(mem_write4), .i_or_d(i_or_d4),
        .ir_write(ir_write4), .pc_write(pc_write4), .pc_source(pc_source4),
        .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .reg_write(reg_write4),
        .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .wwd(wwd4), .halt(halt4),
        .num_inst(num_inst4)
    );

    // Layout: mr mw iod irw pcw pcs[2] asa asb[2] rw rd[2] mtr[2] wwd halt
    logic [16:0] sig;
    assign sig = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
                  alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, wwd, halt};

    localparam logic [16:0] E_NONE = 17'b0_0_0_0_0_00_0_00_0_00_00_0_0;
    localparam logic [16:0] E_IFW  = 17'b1_0_0_0_0_00_0_00_0_00_00_0_0;
    localparam logic [16:0] E_IFD  = 17'b1_0_0_1_1_00_0_00_0_00_00_0_0;
    localparam logic [16:0] E_EXR  = 17'b0_0_0_0_0_00_1_01_0_00_00_0_0;
    localparam logic [16:0] E_EXI  = 17'b0_0_0_0_0_00_1_10_0_00_00_0_0;
    localparam logic [16:0] E_EXBT = 17'b0_0_0_0_1_01_1_01_0_00_00_0_0;
    localparam logic [16:0] E_EXBN = 17'b0_0_0_0_0_01_1_01_0_00_00_0_0;
    localparam logic [16:0] E_MEMR = 17'b1_0_1_0_0_00_0_00_0_00_00_0_0;
    localparam logic [16:0] E_MEMW = 17'b0_1_1_0_0_00_0_00_0_00_00_0_0;
    localparam logic [16:0] E_WBR  = 17'b0_0_0_0_0_00_0_00_1_01_00_0_0;
    localparam logic [16:0] E_WBL  = 17'b0_0_0_0_0_00_0_00_1_00_01_0_0;
    localparam logic [16:0] E_JMP  = 17'b0_0_0_0_1_10_0_00_0_00_00_0_0;
    localparam logic [16:0] E_JAL  = 17'b0_0_0_0_1_10_0_00_1_10_10_0_0;
    localparam logic [16:0] E_JPR  = 17'b0_0_0_0_1_11_0_00_0_00_00_0_0;
    localparam logic [16:0] E_JRL  = 17'b0_0_0_0_1_11_0_00_1_10_10_0_0;
    localparam logic [16:0] E_WWD  = 17'b0_0_0_0_0_00_0_00_0_00_00_1_0;
    localparam logic [16:0] E_HLT  = 17'b0_0_0_0_0_00_0_00_0_00_00_0_1;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic        bc;
        logic [16:0] exp;
    } step_t;

    // Drive one cycle's inputs after the falling edge and let outputs settle.
    task automatic cyc(input logic [3:0] op, input logic [5:0] fn,
                       input logic mr, input logic bc);
        @(negedge clk);
        opcode    = op;
        funct     = fn;
        mem_ready = mr;
        bcond     = bc;
        #1;
    endtask

    task automatic run_steps(input string name, input step_t steps[$]);
        foreach (steps[i]) begin
            cyc(steps[i].op, steps[i].fn, steps[i].mr, steps[i].bc);
            total++;
            if (sig !== steps[i].exp) begin
                bad++;
                $display("FAIL %s step%0d sig=%b expected=%b", name, i, sig, steps[i].exp);
            end
            if (steps[i].exp === E_IFD) exp_cnt++;
        end
        total++;
        if (num_inst !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL %s num_inst=%0d expected=%0d", name, num_inst, exp_cnt);
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (sig !== E_NONE || num_inst !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs sig=%b num=%0d expected sig=0 num=0", sig, num_inst);
        end
        @(posedge clk);
        #2;
        total++;
        if (sig !== E_NONE || num_inst !== 16'd0) begin
            bad++;
            $display("FAIL reset_hold sig=%b num=%0d expected sig=0 num=0", sig, num_inst);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (sig !== E_IFW) begin
            bad++;
            $display("FAIL reset_release sig=%b expected=%b", sig, E_IFW);
        end
        exp_cnt = 0;
    endtask

    task automatic test_add;
        step_t s[$];
        s = '{'{4'd15, 6'd0, 1'b1, 1'b0, E_IFD},
              '{4'd15, 6'd0, 1'b1, 1'b0, E_NONE},
              '{4'd15, 6'd0, 1'b1, 1'b0, E_EXR},
              '{4'd15, 6'd0, 1'b1, 1'b0, E_WBR}};
        run_steps("add", s);
    endtask

    task automatic test_lwd;
        step_t s[$];
        s = '{'{4'd7, 6'd0, 1'b0, 1'b0, E_IFW},
              '{4'd7, 6'd0, 1'b0, 1'b0, E_IFW},
              '{4'd7, 6'd0, 1'b0, 1'b0, E_IFW},
              '{4'd7, 6'd0, 1'b1, 1'b0, E_IFD},
              '{4'd7, 6'd0, 1'b1, 1'b0, E_NONE},
              '{4'd7, 6'd0, 1'b0, 1'b0, E_EXI},
              '{4'd7, 6'd0, 1'b0, 1'b0, E_MEMR},
              '{4'd7, 6'd0, 1'b0, 1'b0, E_MEMR},
              '{4'd7, 6'd0, 1'b0, 1'b0, E_MEMR},
              '{4'd7, 6'd0, 1'b1, 1'b0, E_MEMR},
              '{4'd7, 6'd0, 1'b1, 1'b0, E_WBL},
              '{4'd7, 6'd0, 1'b0, 1'b0, E_IFW}};
        run_steps("lwd", s);
    endtask

    task automatic test_branch;
        step_t s[$];
        s = '{'{4'd0, 6'd0, 1'b1, 1'b1, E_IFD},
              '{4'd0, 6'd0, 1'b1, 1'b1, E_NONE},
              '{4'd0, 6'd0, 1'b1, 1'b1, E_EXBT},
              '{4'd0, 6'd0, 1'b1, 1'b0, E_IFD},
              '{4'd0, 6'd0, 1'b1, 1'b0, E_NONE},
              '{4'd0, 6'd0, 1'b1, 1'b0, E_EXBN},
              '{4'd0, 6'd0, 1'b0, 1'b0, E_IFW}};
        run_steps("branch", s);
    endtask

    task automatic test_jal;
        step_t s[$];
        s = '{'{4'd10, 6'd0, 1'b1, 1'b0, E_IFD},
              '{4'd10, 6'd0, 1'b1, 1'b0, E_JAL},
              '{4'd10, 6'd0, 1'b0, 1'b0, E_IFW}};
        run_steps("jal", s);
    endtask

    task automatic test_misc;
        step_t s[$];
        // JMP, JPR, JRL, undefined opcode 12, undefined funct 40, ORI, SWD
        s = '{'{4'd9,  6'd0,  1'b1, 1'b0, E_IFD},
              '{4'd9,  6'd0,  1'b1, 1'b0, E_JMP},
              '{4'd15, 6'd25, 1'b1, 1'b0, E_IFD},
              '{4'd15, 6'd25, 1'b1, 1'b0, E_JPR},
              '{4'd15, 6'd26, 1'b1, 1'b0, E_IFD},
              '{4'd15, 6'd26, 1'b1, 1'b0, E_JRL},
              '{4'd12, 6'd0,  1'b1, 1'b0, E_IFD},
              '{4'd12, 6'd0,  1'b1, 1'b0, E_NONE},
              '{4'd15, 6'd40, 1'b1, 1'b0, E_IFD},
              '{4'd15, 6'd40, 1'b1, 1'b0, E_NONE},
              '{4'd5,  6'd0,  1'b1, 1'b0, E_IFD},
              '{4'd5,  6'd0,  1'b1, 1'b0, E_NONE},
              '{4'd5,  6'd0,  1'b1, 1'b0, E_EXI},
              '{4'd5,  6'd0,  1'b1, 1'b0, 17'b0_0_0_0_0_00_0_00_1_00_00_0_0},
              '{4'd8,  6'd0,  1'b1, 1'b0, E_IFD},
              '{4'd8,  6'd0,  1'b1, 1'b0, E_NONE},
              '{4'd8,  6'd0,  1'b1, 1'b0, E_EXI},
              '{4'd8,  6'd0,  1'b1, 1'b0, E_MEMW},
              '{4'd8,  6'd0,  1'b1, 1'b0, E_IFD},
              '{4'd8,  6'd0,  1'b1, 1'b0, E_NONE},
              '{4'd8,  6'd0,  1'b0, 1'b0, E_EXI},
              '{4'd8,  6'd0,  1'b0, 1'b0, E_MEMW}};
        run_steps("misc", s);
        // Abandon the pending store with an asynchronous reset.
        #2 reset = 1'b1;
        #1;
        total++;
        if (sig !== E_NONE || num_inst !== 16'd0) begin
            bad++;
            $display("FAIL reset_in_mem sig=%b num=%0d expected sig=0 num=0", sig, num_inst);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        exp_cnt = 0;
        total++;
        if (sig !== E_IFW) begin
            bad++;
            $display("FAIL after_mem_reset sig=%b expected=%b", sig, E_IFW);
        end
    endtask

    task automatic test_halt;
        step_t s[$];
        s = '{'{4'd15, 6'd29, 1'b1, 1'b0, E_IFD},
              '{4'd15, 6'd29, 1'b1, 1'b0, E_NONE}};
        for (int i = 0; i < 10; i++)
            s.push_back('{4'd15, 6'd29, 1'(i % 2), 1'b0, E_HLT});
        run_steps("halt", s);
        #2 reset = 1'b1;
        #1;
        total++;
        if (halt !== 1'b0 || sig !== E_NONE || num_inst !== 16'd0) begin
            bad++;
            $display("FAIL halt_reset halt=%b sig=%b num=%0d expected halt=0 sig=0 num=0",
                     halt, sig, num_inst);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        exp_cnt = 0;
        total++;
        if (sig !== E_IFW) begin
            bad++;
            $display("FAIL halt_reset_release sig=%b expected=%b", sig, E_IFW);
        end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(4'd15, 6'd28, 1'b1, 1'b0);
            total++;
            if (sig !== E_IFD) begin
                bad++;
                $display("FAIL wwd_if%0d sig=%b expected=%b", i, sig, E_IFD);
            end
            cyc(4'd15, 6'd28, 1'b1, 1'b0);
            if (wwd4 === 1'b1) pulses++;
            total++;
            if (sig !== E_WWD) begin
                bad++;
                $display("FAIL wwd_id%0d sig=%b expected=%b", i, sig, E_WWD);
            end
            total++;
            if (num_inst4 !== 4'(i + 1)) begin
                bad++;
                $display("FAIL wrap%0d num_inst4=%0d expected=%0d", i, num_inst4, (i + 1) % 16);
            end
        end
        total++;
        if (pulses !== 16) begin
            bad++;
            $display("FAIL wwd_pulses got=%0d expected=16", pulses);
        end
        total++;
        if (num_inst !== 16'd16) begin
            bad++;
            $display("FAIL wide_count num_inst=%0d expected=16", num_inst);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_lwd;
        test_branch;
        test_jal;
        test_misc;
        test_halt;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
